seq_hit_monitor: RTL and testbench

SEQ_HIT_MONITOR -- requirements
Module: seq_hit_monitor

---
 rtl/seq_pkg.sv | 19 +
 rtl/sat_counter.sv | 28 ++
 rtl/seq_hit_monitor.sv | 154 +++++++++++++++
 tb/tb_seq_hit_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-hit monitor: FSM state encoding,
// default parameter values and the fixed width of the window bookkeeping.
package seq_pkg;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_GAP_W  = 8;
    localparam int DEF_WINDOW = 16;
    localparam int DEF_THRESH = 3;

    // Window timer and window hit counter never exceed 255, so 8 bits suffice
    localparam int TMR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ALARM = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low
// reset. Clear wins over increment; the count sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // Count up on inc_i until all-ones is reached, zero on clear or reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_hit_monitor.sv
// Monitors the one-cycle hit pulses of a 1101 sequence detector: keeps a
// saturating total, measures the gap between consecutive hits, and raises a
// sticky alarm when THRESH hits land inside one WINDOW-cycle burst window.
module seq_hit_monitor
    import seq_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int GAP_W  = DEF_GAP_W,
    parameter int WINDOW = DEF_WINDOW,
    parameter int THRESH = DEF_THRESH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit,
    input  logic             clr,
    output logic [CNT_W-1:0] hit_count,
    output logic [GAP_W-1:0] last_gap,
    output logic             gap_valid,
    output logic             alarm,
    output logic [1:0]       state
);

    // Reject parameter sets that make the burst window meaningless
    if ((WINDOW < 2) || (WINDOW > 255) || (THRESH < 2) || (THRESH > WINDOW)
        || (CNT_W < 1) || (GAP_W < 1)) begin : gParamCheck
        $error("seq_hit_monitor: illegal WINDOW/THRESH/width parameters");
    end

    // The window spans WINDOW edges counting the opening hit edge, so the
    // decision edge is the one on which the timer would reach WINDOW-1.
    localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WINDOW - 2);
    localparam logic [TMR_W-1:0] THRESH_L = TMR_W'(THRESH);

    state_e             state_q;
    logic [TMR_W-1:0]   win_timer_q;
    logic [TMR_W-1:0]   win_hits_q;
    logic               alarm_q;
    logic [GAP_W-1:0]   last_gap_q;
    logic               gap_valid_q;

    logic [TMR_W-1:0]   win_timer_d;
    logic [TMR_W-1:0]   win_hits_d;
    logic [GAP_W-1:0]   last_gap_d;
    logic [GAP_W-1:0]   gap_cnt;
    logic               gap_clr;
    logic               tracking;

    assign win_timer_d = win_timer_q + TMR_W'(1);
    assign win_hits_d  = win_hits_q + TMR_W'(1);

    // A hit edge measures the gap including itself, saturating at all-ones
    assign last_gap_d = (gap_cnt == {GAP_W{1'b1}}) ? {GAP_W{1'b1}} : (gap_cnt + GAP_W'(1));

    // Gap counter restarts on every hit so it always measures from the latest one
    assign gap_clr  = clr | hit;
    assign tracking = (state_q != IDLE);

    sat_counter #(
        .W (CNT_W)
    ) u_hit_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .inc_i   (hit),
        .count_o (hit_count)
    );

    sat_counter #(
        .W (GAP_W)
    ) u_gap_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (gap_clr),
        .inc_i   (1'b1),
        .count_o (gap_cnt)
    );

    // Burst-window FSM: threshold check beats window expiry, ALARM is sticky
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            win_timer_q <= '0;
            win_hits_q  <= '0;
            alarm_q     <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            win_timer_q <= '0;
            win_hits_q  <= '0;
            alarm_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        state_q     <= TRACK;
                        win_timer_q <= '0;
                        win_hits_q  <= TMR_W'(1);
                    end
                end
                TRACK: begin
                    if (hit && (win_hits_d == THRESH_L)) begin
                        state_q     <= ALARM;
                        alarm_q     <= 1'b1;
                        win_timer_q <= win_timer_d;
                        win_hits_q  <= win_hits_d;
                    end else if (win_timer_q == WIN_LAST) begin
                        win_timer_q <= '0;
                        if (hit) begin
                            win_hits_q <= TMR_W'(1);
                        end else begin
                            state_q    <= IDLE;
                            win_hits_q <= '0;
                        end
                    end else begin
                        win_timer_q <= win_timer_d;
                        if (hit) begin
                            win_hits_q <= win_hits_d;
                        end
                    end
                end
                ALARM: begin
                    alarm_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    win_timer_q <= '0;
                    win_hits_q  <= '0;
                    alarm_q     <= 1'b0;
                end
            endcase
        end
    end

    // Capture the inter-hit gap on hits seen while a window is open or alarmed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gap_q  <= '0;
            gap_valid_q <= 1'b0;
        end else if (clr) begin
            last_gap_q  <= '0;
            gap_valid_q <= 1'b0;
        end else begin
            gap_valid_q <= hit && tracking;
            if (hit && tracking) begin
                last_gap_q <= last_gap_d;
            end
        end
    end

    assign last_gap  = last_gap_q;
    assign gap_valid = gap_valid_q;
    assign alarm     = alarm_q;
    assign state     = state_q;

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Self-checking bench for seq_hit_monitor: directed scenarios plus random
// hit/clear/reset traffic, compared every cycle against a timestamp-based
// reference model.
module tb_seq_hit_monitor;

    localparam int CNT_W   = 8;
    localparam int GAP_W   = 8;
    localparam int WINDOW  = 16;
    localparam int THRESH  = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int GAP_MAX = (1 << GAP_W) - 1;

    logic             clk;
    logic             rst;
    logic             hit;
    logic             clr;
    logic [CNT_W-1:0] hit_count;
    logic [GAP_W-1:0] last_gap;
    logic             gap_valid;
    logic             alarm;
    logic [1:0]       state;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: edge number, edge of the last gap restart, window start
    int  t        = 0;
    int  gapRef   = 0;
    int  winStart = 0;
    int  winHits  = 0;
    int  mMode    = 0;
    int  mHitCount = 0;
    int  mLastGap  = 0;
    bit  mGapValid = 0;

    seq_hit_monitor #(
        .CNT_W  (CNT_W),
        .GAP_W  (GAP_W),
        .WINDOW (WINDOW),
        .THRESH (THRESH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hit       (hit),
        .clr       (clr),
        .hit_count (hit_count),
        .last_gap  (last_gap),
        .gap_valid (gap_valid),
        .alarm     (alarm),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int satMin(int v, int m);
        return (v > m) ? m : v;
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at model edge %0d: observed %0d, expected %0d",
                     tag, t, observed, expected);
        end
    endtask

    // Compare every output against the model
    task automatic checkAll(input string tag);
        checkOutput({tag, ".hit_count"}, int'(hit_count), mHitCount);
        checkOutput({tag, ".last_gap"},  int'(last_gap),  mLastGap);
        checkOutput({tag, ".gap_valid"}, int'(gap_valid), int'(mGapValid));
        checkOutput({tag, ".alarm"},     int'(alarm),     (mMode == 2) ? 1 : 0);
        checkOutput({tag, ".state"},     int'(state),     mMode);
    endtask

    // Reset discards all history; the gap restarts from the current edge
    task automatic modelReset();
        mMode     = 0;
        mHitCount = 0;
        mLastGap  = 0;
        mGapValid = 0;
        winHits   = 0;
        winStart  = t;
        gapRef    = t;
    endtask

    // Behaviour of one rising edge expressed with timestamps and counts
    task automatic modelEdge(input bit h, input bit c);
        t++;
        mGapValid = 0;
        if (c) begin
            modelReset();
        end else begin
            if (h) begin
                mHitCount = satMin(mHitCount + 1, CNT_MAX);
                if (mMode != 0) begin
                    mLastGap  = satMin(t - gapRef, GAP_MAX);
                    mGapValid = 1;
                end
                gapRef = t;
            end
            case (mMode)
                0: if (h) begin
                    mMode    = 1;
                    winStart = t;
                    winHits  = 1;
                end
                1: begin
                    if (h && (winHits + 1 >= THRESH)) begin
                        mMode = 2;
                    end else if (t - winStart == WINDOW - 1) begin
                        if (h) begin
                            winStart = t;
                            winHits  = 1;
                        end else begin
                            mMode = 0;
                        end
                    end else if (h) begin
                        winHits++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle of inputs, advance the model and check 1 time unit later
    task automatic applyStimulus(input bit h, input bit c);
        hit = h;
        clr = c;
        @(posedge clk);
        modelEdge(h, c);
        #1;
        checkAll(c ? "clr" : "cyc");
    endtask

    // Pull reset low between edges, check outputs at once, release mid-cycle
    task automatic applyReset();
        #2;
        rst = 1'b0;
        hit = 1'b0;
        clr = 1'b0;
        #1;
        modelReset();
        checkAll("async_rst");
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        bit h;
        bit c;
        bit burstMode;
        rst = 1'b0;
        hit = 1'b0;
        clr = 1'b0;
        burstMode = 1'b0;

        // Reset held across edges, then released away from an edge
        @(posedge clk);
        @(posedge clk);
        #1;
        modelReset();
        checkAll("reset");
        #2;
        rst = 1'b1;

        // Hits at relative edges 3, 7, 12: gaps 4 and 5, alarm on the third
        for (int i = 0; i < 14; i++) begin
            applyStimulus((i == 3) || (i == 7) || (i == 12), 1'b0);
        end

        // Alarm is sticky across a long quiet stretch; the gap saturates
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0);

        // Clear together with a hit: the hit is ignored
        applyStimulus(1'b1, 1'b1);

        // Hits 20 edges apart: window expires back to IDLE in between
        for (int i = 0; i <= 20; i++) begin
            applyStimulus((i == 0) || (i == 20), 1'b0);
        end
        applyStimulus(1'b0, 1'b1);

        // Hits exactly at the window edge restart the window
        for (int i = 0; i < 40; i++) begin
            applyStimulus((i % (WINDOW - 1)) == 0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1);

        // Long run of consecutive hits: count saturates, gap stays 1
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1);

        // Reset in the middle of a window with two hits recorded
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyReset();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // Random traffic alternating sparse and bursty phases
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                applyReset();
            end else begin
                h = burstMode ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
                c = ($urandom_range(0, 79) == 0);
                applyStimulus(h, c);
            end
            if ($urandom_range(0, 99) == 0) begin
                burstMode = !burstMode;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
